// File: rtl/future_subcell_serial_pkg.sv
// Shared definitions for the FUTURE nibble-serial SubCell datapath.
package future_pkg;

  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble 0 is the most significant nibble of the state.
  function automatic logic [3:0] nibble_of(input logic [STATE_W-1:0] s, input int idx);
    logic [STATE_W-1:0] sh;
    sh = s >> (STATE_W - 4 - 4 * idx);
    return sh[3:0];
  endfunction

endpackage

// File: rtl/future_subcell_serial_lanes.sv
// LANES parallel S-boxes; lane 0 handles the most significant nibble.
module subcell_lanes #(
  parameter int LANES = 1
) (
  input  logic [4*LANES-1:0] in_bits,
  output logic [4*LANES-1:0] out_bits
);

  localparam int LW = 4 * LANES;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox u_sbox (
      .x0 (in_bits[LW-1-4*j]),
      .x1 (in_bits[LW-2-4*j]),
      .x2 (in_bits[LW-3-4*j]),
      .x3 (in_bits[LW-4-4*j]),
      .y0 (out_bits[LW-1-4*j]),
      .y1 (out_bits[LW-2-4*j]),
      .y2 (out_bits[LW-3-4*j]),
      .y3 (out_bits[LW-4-4*j])
    );
  end

endmodule

// File: rtl/sbox.sv
// FUTURE 4-bit S-box, purely combinational. x0/y0 carry the nibble MSB.
module sbox (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3
);

  logic [3:0] v;
  logic [3:0] s;

  assign v = {x0, x1, x2, x3};

  // Substitution table lookup.
  always_comb begin
    s = 4'h0;
    case (v)
      4'h0: s = 4'h1;
      4'h1: s = 4'h3;
      4'h2: s = 4'h0;
      4'h3: s = 4'h2;
      4'h4: s = 4'h7;
      4'h5: s = 4'hE;
      4'h6: s = 4'h4;
      4'h7: s = 4'hD;
      4'h8: s = 4'h9;
      4'h9: s = 4'hB;
      4'hA: s = 4'h8;
      4'hB: s = 4'h5;
      4'hC: s = 4'hF;
      4'hD: s = 4'hC;
      4'hE: s = 4'h6;
      4'hF: s = 4'hA;
      default: s = 4'h0;
    endcase
  end

  assign {y0, y1, y2, y3} = s;

endmodule

// File: rtl/future_subcell_serial.sv
// Nibble-serial SubCell layer: substitutes a 64-bit state LANES nibbles per
// cycle by rotating it through a shift register in front of the S-boxes.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid is held with stable data until accepted, and ready may
// depend combinationally on the other side only for in_ready <- out_ready.
module future_subcell_serial
  import future_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int NCYC  = NIBBLES / LANES;
  localparam int LW    = 4 * LANES;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("LANES must be one of 1, 2, 4, 8, 16");
  end

  state_t             state_q, state_d;
  logic [STATE_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]      lanes_in, lanes_out;
  logic [STATE_W-1:0] lanes_ext;

  assign lanes_in  = sreg_q[STATE_W-1 -: LW];
  assign lanes_ext = STATE_W'(lanes_out);

  subcell_lanes #(.LANES(LANES)) u_lanes (
    .in_bits  (lanes_in),
    .out_bits (lanes_out)
  );

  // State, shift register and counter; reset discards any state in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load, rotate-and-substitute, then hold until consumed.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // After NCYC rotations every nibble is back in its original slot.
        sreg_d = (sreg_q << LW) | lanes_ext;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCYC - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            sreg_d  = in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = sreg_q;

endmodule

// File: tb/tb_future_subcell_serial.sv
// Directed bench for future_subcell_serial across LANES = 1, 2, 4, 16.
module tb_future_subcell_serial;
  import future_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, out_ready;
  logic [63:0] in_data;
  logic        ir [4];
  logic        ov [4];
  logic        bz [4];
  logic [63:0] od [4];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    future_subcell_serial #(.LANES((g == 3) ? 16 : (1 << g))) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .busy      (bz[g])
    );
  end

  // Standalone S-box tabulated against the published table.
  logic [3:0] sx, sy;
  sbox u_ref (
    .x0 (sx[3]), .x1 (sx[2]), .x2 (sx[1]), .x3 (sx[0]),
    .y0 (sy[3]), .y1 (sy[2]), .y2 (sy[1]), .y3 (sy[0])
  );

  logic [3:0] s_tab [16] = '{4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
                             4'h9, 4'hB, 4'h8, 4'h5, 4'hF, 4'hC, 4'h6, 4'hA};
  int lat_exp [4] = '{16, 8, 4, 1};

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [4];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
  endtask

  // ---------------- driver: one transfer on all lane variants ----------------
  task automatic transfer(input logic [63:0] din, input logic [63:0] exp);
    int first [4];
    in_data   = din;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("idle_in_ready", 64'(ir[0]), 64'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) first[i] = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (first[i] != 0 && k == first[i] + 1)
          chk($sformatf("one_cycle_valid_l%0d", i), 64'(ov[i]), 64'd0);
        if (ov[i] && first[i] == 0) begin
          first[i] = k;
          chk($sformatf("data_l%0d", i), od[i], exp);
          if (i == 0) begin
            for (int n = 0; n < NIBBLES; n++)
              chk($sformatf("model_nib%0d", n), 64'(nibble_of(od[0], n)),
                  64'(s_tab[nibble_of(din, n)]));
          end
        end
      end
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("latency_l%0d", i), 64'(first[i]), 64'(lat_exp[i]));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int waited;
    int stale;

    vecs[0] = '{64'h0123456789ABCDEF, 64'h13027E4D9B85FC6A};
    vecs[1] = '{64'h0000000000000000, 64'h1111111111111111};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA};
    vecs[3] = '{64'hFEDCBA9876543210, 64'hA6CF58B9D4E72031};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; sx = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_out_data", od[0], 64'd0);
      chk("rst_busy", 64'(bz[0]), 64'd0);
    end

    for (int v = 0; v < 16; v++) begin
      sx = 4'(v);
      #1;
      chk($sformatf("sbox_%0d", v), 64'(sy), 64'(s_tab[v]));
    end

    // Table-driven transfers, including the all-zero and all-one states.
    for (int t = 0; t < 4; t++) begin
      transfer(vecs[t].din, vecs[t].exp);
      drain();
    end

    // Backpressure then back-to-back acceptance in DONE.
    in_data = vecs[0].din; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!ov[0] && waited < 40) begin
      tick();
      waited++;
    end
    chk("bp_reach_done", 64'(ov[0]), 64'd1);
    in_data  = 64'hFFFF0000FFFF0000;
    in_valid = 1'b1;
    repeat (7) begin
      tick();
      chk("bp_hold_data", od[0], vecs[0].exp);
      chk("bp_hold_valid", 64'(ov[0]), 64'd1);
      chk("bp_in_ready", 64'(ir[0]), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_comb_ready", 64'(ir[0]), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_reload_busy", 64'(bz[0]), 64'd1);
    chk("bp_reload_valid", 64'(ov[0]), 64'd0);
    waited = 0;
    while (!ov[0] && waited < 40) begin
      tick();
      waited++;
    end
    chk("bp_second_latency", 64'(waited), 64'd16);
    chk("bp_second_data", od[0], 64'hAAAA1111AAAA1111);
    drain();

    // Reset while the counter sits at 5.
    in_data = vecs[0].din; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("mid_busy", 64'(bz[0]), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(ov[0]), 64'd0);
    chk("mid_rst_data", od[0], 64'd0);
    chk("mid_rst_busy", 64'(bz[0]), 64'd0);
    chk("mid_rst_ready", 64'(ir[0]), 64'd1);
    rst = 1'b0;
    stale = 0;
    repeat (20) begin
      tick();
      if (ov[0]) stale++;
    end
    chk("mid_no_stale", 64'(stale), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
